// File: rtl/delay_line_n_if.sv
// Handshake bundle for delay_line_n: shift/flush controls, input word, tap select and tapped outputs.
// master drives the line, slave is the delay line itself.
interface delay_line_n_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
);
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [SEL_W-1:0] dly_sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             primed;

    modport master (
        output en, flush, d, d_valid, dly_sel,
        input  q, q_valid, primed
    );

    modport slave (
        input  en, flush, d, d_valid, dly_sel,
        output q, q_valid, primed
    );
endinterface

// File: rtl/delay_line_n.sv
// Run-time selectable pipeline delay (1..DEPTH enabled cycles) for a data word plus valid flag.
// The output is a combinational tap into the register chain, so dly_sel changes act immediately.
module delay_line_n #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int SEL_W = 3
) (
    input logic           clk,
    input logic           rst,
    delay_line_n_if.slave bus
);

    localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(DEPTH - 1);

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] stage_v;
    logic [SEL_W-1:0] tap;
    logic             primed_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data stages are reset too, since q must read 0 as soon as rst asserts.
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] <= '0;
            end
            stage_v <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] <= '0;
            end
            stage_v <= '0;
        end else if (bus.en) begin
            // NOTE: non-blocking assignments let each stage take its neighbour's old value, so the loop shifts by one.
            stage_d[0] <= bus.d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] <= stage_d[i-1];
            end
            stage_v <= {stage_v[DEPTH-2:0], bus.d_valid};
        end
    end

    // Out-of-range selects clamp to the oldest stage rather than wrapping.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        tap = bus.dly_sel;
        if (int'(bus.dly_sel) > DEPTH - 1) begin
            tap = LAST_TAP;
        end
    end

    always_comb begin
        primed_c = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i <= int'(tap)) begin
                primed_c = primed_c & stage_v[i];
            end
        end
    end

    assign bus.q       = stage_d[tap];
    assign bus.q_valid = stage_v[tap];
    assign bus.primed  = primed_c;

endmodule

// File: tb/tb_delay_line_n.sv
// Self-checking bench for delay_line_n: vector table, hand-written tap/clamp sequences
// and a randomised stream compared through a scoreboard queue.
module tb_delay_line_n;

    typedef struct {
        logic        en;
        logic        flush;
        logic [15:0] d;
        logic        dv;
        logic [2:0]  sel;
        logic [15:0] q;
        logic        qv;
        logic        pr;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic        qv;
        logic        pr;
    } exp_t;

    localparam int M_DEPTH = 8;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    vec_t vecs[$];
    exp_t sb[$];
    logic [15:0] m_d [M_DEPTH];
    logic        m_v [M_DEPTH];

    delay_line_n_if #(.WIDTH(16), .SEL_W(3)) a ();
    delay_line_n_if #(.WIDTH(16), .SEL_W(3)) b ();

    delay_line_n #(.WIDTH(16), .DEPTH(8), .SEL_W(3)) dut8 (.clk(clk), .rst(rst), .bus(a));
    delay_line_n #(.WIDTH(16), .DEPTH(6), .SEL_W(3)) dut6 (.clk(clk), .rst(rst), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string name, input logic [15:0] q, input logic qv, input logic pr);
        check({name, " q"}, 32'(a.q), 32'(q));
        check({name, " q_valid"}, 32'(a.q_valid), 32'(qv));
        check({name, " primed"}, 32'(a.primed), 32'(pr));
    endtask

    task automatic check_b(input string name, input logic [15:0] q, input logic qv, input logic pr);
        check({name, " q"}, 32'(b.q), 32'(q));
        check({name, " q_valid"}, 32'(b.q_valid), 32'(qv));
        check({name, " primed"}, 32'(b.primed), 32'(pr));
    endtask

    task automatic drive_a(input logic en, input logic fl, input logic [15:0] d, input logic dv,
                           input logic [2:0] sel);
        a.en = en; a.flush = fl; a.d = d; a.d_valid = dv; a.dly_sel = sel;
    endtask

    task automatic drive_b(input logic en, input logic fl, input logic [15:0] d, input logic dv,
                           input logic [2:0] sel);
        b.en = en; b.flush = fl; b.d = d; b.d_valid = dv; b.dly_sel = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic en, input logic fl, input logic [15:0] d, input logic dv);
        if (fl) begin
            for (int i = 0; i < M_DEPTH; i++) begin
                m_d[i] = '0;
                m_v[i] = 1'b0;
            end
        end else if (en) begin
            for (int i = M_DEPTH - 1; i > 0; i--) begin
                m_d[i] = m_d[i-1];
                m_v[i] = m_v[i-1];
            end
            m_d[0] = d;
            m_v[0] = dv;
        end
    endtask

    function automatic exp_t model_out(input logic [2:0] sel);
        exp_t e;
        int   tp;
        tp = int'(sel);
        if (tp > M_DEPTH - 1) tp = M_DEPTH - 1;
        e.q  = m_d[tp];
        e.qv = m_v[tp];
        e.pr = 1'b1;
        for (int i = 0; i <= tp; i++) e.pr = e.pr & m_v[i];
        return e;
    endfunction

    initial begin
        // en, flush, d, dv, sel, exp q, exp q_valid, exp primed
        vecs.push_back('{1'b1, 1'b1, 16'h0009, 1'b1, 3'd3, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0001, 1'b1, 3'd3, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0002, 1'b1, 3'd3, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0003, 1'b1, 3'd3, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0004, 1'b1, 3'd3, 16'h0001, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 16'h0005, 1'b1, 3'd3, 16'h0002, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 16'h0006, 1'b1, 3'd3, 16'h0003, 1'b1, 1'b1});
        // stall at tap 0: B is never captured
        vecs.push_back('{1'b1, 1'b0, 16'h000A, 1'b1, 3'd0, 16'h000A, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 16'h000B, 1'b1, 3'd0, 16'h000A, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 16'h000C, 1'b1, 3'd0, 16'h000C, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 16'h000D, 1'b1, 3'd1, 16'h000C, 1'b1, 1'b1});
        // bubble at tap 2
        vecs.push_back('{1'b1, 1'b1, 16'h0009, 1'b1, 3'd2, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0061, 1'b1, 3'd2, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0062, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0063, 1'b1, 3'd2, 16'h0061, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0064, 1'b1, 3'd2, 16'h0062, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0065, 1'b1, 3'd2, 16'h0063, 1'b1, 1'b1});
        // fill at tap 7, then flush with en=1 drops the 9
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 1'b0, 3'd7, 16'h0000, 1'b0, 1'b0});
        for (int k = 1; k <= 7; k++)
            vecs.push_back('{1'b1, 1'b0, 16'(16'h0070 + k), 1'b1, 3'd7, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0078, 1'b1, 3'd7, 16'h0071, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 16'h0009, 1'b1, 3'd7, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0080, 1'b1, 3'd7, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 16'h0081, 1'b1, 3'd0, 16'h0080, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 16'h0082, 1'b1, 3'd1, 16'h0000, 1'b0, 1'b0});

        rst = 1'b1;
        drive_a(1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
        drive_b(1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
        #1;
        check_a("reset", 16'h0, 1'b0, 1'b0);
        check_b("reset6", 16'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // async reset lands mid-cycle and clears outputs before the next edge
        drive_a(1'b1, 1'b0, 16'hFFFF, 1'b1, 3'd0);
        tick();
        check_a("pre_rst", 16'hFFFF, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_a("async_rst", 16'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive_a(vecs[i].en, vecs[i].flush, vecs[i].d, vecs[i].dv, vecs[i].sel);
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].q, vecs[i].qv, vecs[i].pr);
        end

        // tap change without clearing: stream 10..19 at tap 5
        drive_a(1'b1, 1'b1, 16'h0, 1'b0, 3'd5);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive_a(1'b1, 1'b0, 16'(10 + k), 1'b1, 3'd5);
            tick();
            if (k == 5) check_a("tap5_first", 16'd10, 1'b1, 1'b1);
        end
        check_a("tap5_run", 16'd14, 1'b1, 1'b1);
        a.en = 1'b0;
        a.dly_sel = 3'd1;
        #1;
        check_a("tap_to1", 16'd18, 1'b1, 1'b1);
        a.dly_sel = 3'd7;
        #1;
        check_a("tap_to7", 16'd12, 1'b1, 1'b1);
        tick();
        check_a("tap7_hold", 16'd12, 1'b1, 1'b1);

        // clamp on the 6-deep line: dly_sel=7 behaves as tap 5
        drive_b(1'b1, 1'b1, 16'h0, 1'b0, 3'd7);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive_b(1'b1, 1'b0, 16'(20 + k), 1'b1, 3'd7);
            tick();
            if (k == 4) check_b("clamp_e5", 16'd0, 1'b0, 1'b0);
            if (k == 5) check_b("clamp_e6", 16'd20, 1'b1, 1'b1);
        end
        check_b("clamp_e8", 16'd22, 1'b1, 1'b1);
        b.en = 1'b0;
        b.dly_sel = 3'd5;
        #1;
        check_b("clamp_sel5", 16'd22, 1'b1, 1'b1);
        b.dly_sel = 3'd4;
        #1;
        check_b("clamp_sel4", 16'd23, 1'b1, 1'b1);

        // randomised stream against the reference model through the scoreboard
        for (int k = 0; k < 400; k++) begin
            logic        en_r, fl_r, dv_r;
            logic [15:0] d_r;
            logic [2:0]  sel_r;
            exp_t        e;
            en_r  = ($urandom_range(0, 3) != 0);
            fl_r  = (k == 0) || ($urandom_range(0, 24) == 0);
            dv_r  = ($urandom_range(0, 4) != 0);
            d_r   = 16'($urandom);
            sel_r = 3'($urandom_range(0, 7));
            drive_a(en_r, fl_r, d_r, dv_r, sel_r);
            model_step(en_r, fl_r, d_r, dv_r);
            sb.push_back(model_out(sel_r));
            tick();
            e = sb.pop_front();
            check_a($sformatf("rand%0d", k), e.q, e.qv, e.pr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
